// File: rtl/bubble_timing_pkg.sv
// Bubble memory emulator timing: shared access states
// and default loop / page / rotation geometry.
package bubble_timing_pkg;

  typedef logic [2:0] acc_t;

  localparam acc_t ACC_RST  = 3'b000;
  localparam acc_t ACC_STBY = 3'b001;
  localparam acc_t ACC_BOOT = 3'b110;
  localparam acc_t ACC_USER = 3'b111;
  localparam acc_t ACC_IDLE = 3'b100;

  localparam int LOOP_POS  = 2053;
  localparam int PAGE_BITS = 584;
  localparam int CYC_CLKS  = 480;

  // {nBSS, nBSEN, nREPEN, nBOOTEN} with control gated off
  localparam logic [3:0] SYNC_IDLE = 4'b1110;

endpackage

// File: rtl/bubble_timing_gen_p_if.sv
// Control strobes in, timing / position / tick
// numbers out of the bubble timing generator.
interface bubble_timing_gen_p_if #(
  parameter int POS_W  = 12,
  parameter int TICK_W = 15
);
  logic              nINCTRL;
  logic              nBSS;
  logic              nBSEN;
  logic              nREPEN;
  logic              nBOOTEN;
  logic [POS_W-1:0]  TARGETPOS;
  logic              CLKOUT;
  logic [2:0]        ACCTYPE;
  logic              BOUTVALID;
  logic [TICK_W-3:0] BOUTCYCLENUM;
  logic [1:0]        BOUTTICKS;
  logic [POS_W-1:0]  ABSPOS;
  logic              POSMATCH;

  modport master (
    output nINCTRL, nBSS, nBSEN, nREPEN,
    output nBOOTEN, TARGETPOS,
    input  CLKOUT, ACCTYPE, BOUTVALID,
    input  BOUTCYCLENUM, BOUTTICKS,
    input  ABSPOS, POSMATCH
  );

  modport slave (
    input  nINCTRL, nBSS, nBSEN, nREPEN,
    input  nBOOTEN, TARGETPOS,
    output CLKOUT, ACCTYPE, BOUTVALID,
    output BOUTCYCLENUM, BOUTTICKS,
    output ABSPOS, POSMATCH
  );
endinterface

// File: rtl/bubble_sync_chain.sv
// Multi-stage synchroniser for the four conditioned
// bubble control strobes.
module bubble_sync_chain
  import bubble_timing_pkg::*;
#(
  parameter int STAGES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] sr [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++)
        sr[i] <= SYNC_IDLE;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < STAGES; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/bubble_timing_gen_p.sv
// Bubble-side clock, access FSM, field phase, loop
// position and valid-tick numbering for the emulator.
module bubble_timing_gen_p
  import bubble_timing_pkg::*;
#(
  parameter int CLKDIV      = 6,
  parameter int CYC_LEN     = CYC_CLKS,
  parameter int POS_W       = 12,
  parameter int POS_COUNT   = LOOP_POS,
  parameter int INIT_POS    = 1954,
  parameter int SYNC_STAGES = 4,
  parameter int SKIP_TICKS  = 392,
  parameter int BOOT_TICKS  = LOOP_POS * 2 * 4,
  parameter int PAGE_TICKS  = PAGE_BITS * 4,
  parameter int GAP_TICKS   = 4,
  parameter int TICK_W      = 15
) (
  input logic            MCLK,
  input logic            RESET,
  bubble_timing_gen_p_if.slave bus
);

  localparam int Q     = CYC_LEN / 4;
  localparam int PH_W  = $clog2(CYC_LEN);
  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int TMAX  = 2 ** TICK_W;

  if (CYC_LEN % 4 != 0 || CYC_LEN < 4 ||
      SYNC_STAGES < 2 || CLKDIV < 1 ||
      POS_COUNT > 2 ** POS_W || INIT_POS >= POS_COUNT ||
      SKIP_TICKS >= TMAX || BOOT_TICKS >= TMAX ||
      PAGE_TICKS >= TMAX || GAP_TICKS >= TMAX ||
      GAP_TICKS < 1 || TICK_W < 3) begin : g_bad_param
    $error("bubble_timing_gen_p: bad parameters");
  end

  logic [DIV_W-1:0]  div_cnt;
  logic              clkout;
  logic [3:0]        sync_d;
  logic [3:0]        sync_q;
  logic [3:0]        key;
  acc_t              state;
  acc_t              nxt;
  acc_t              acctype;
  logic [PH_W-1:0]   ph;
  logic              run;
  logic              stop;
  logic              tick;
  logic [TICK_W-1:0] sk;
  logic [TICK_W-1:0] vc;
  logic [TICK_W-1:0] gc;
  logic              valid;
  logic              in_gap;
  logic [POS_W-1:0]  abspos;
  logic              adv;
  logic              posmatch;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      div_cnt <= '0;
      clkout  <= 1'b1;
    end else if (div_cnt == DIV_W'(CLKDIV - 1)) begin
      div_cnt <= '0;
      clkout  <= ~clkout;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign sync_d = {
    bus.nBSS | bus.nINCTRL,
    bus.nBSEN | bus.nINCTRL,
    bus.nINCTRL | bus.nREPEN | ~bus.nBOOTEN,
    ~bus.nINCTRL & bus.nBOOTEN
  };

  bubble_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (MCLK),
    .rst (RESET),
    .d   (sync_d),
    .q   (sync_q)
  );

  // key = {BSS, BOOTEN, BSEN, REPEN}
  assign key = {sync_q[3], sync_q[0], sync_q[2], sync_q[1]};

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) state <= ACC_RST;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      key[1:0] == 2'b11 && key[3]:
        nxt = (state == ACC_STBY) ? ACC_STBY : ACC_RST;
      key[1:0] == 2'b11 && !key[3]:
        if (state == ACC_RST) nxt = ACC_STBY;
      key == 4'b1001:
        if (state inside {ACC_STBY, ACC_RST, ACC_BOOT})
          nxt = ACC_BOOT;
      key == 4'b1101:
        if (state inside {ACC_STBY, ACC_RST})
          nxt = ACC_IDLE;
      key == 4'b1100:
        if (state == ACC_IDLE) nxt = ACC_USER;
      default: ;
    endcase
  end

  always_comb begin
    acctype = state;
  end

  // a field cycle started always runs on to Q-1 or to 0
  assign run  = state[2] | (ph != '0);
  assign stop = ~state[2] & (ph == PH_W'(Q - 1));
  assign tick = run & ((ph == '0) |
                       (ph == PH_W'(Q)) |
                       (ph == PH_W'(2 * Q)) |
                       (ph == PH_W'(3 * Q)));

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET)
      ph <= '0;
    else if (!run || stop)
      ph <= '0;
    else if (ph == PH_W'(CYC_LEN - 1))
      ph <= '0;
    else
      ph <= ph + 1'b1;
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      sk <= '0; vc <= '1; gc <= '0;
      valid <= 1'b0; in_gap <= 1'b0;
    end else if (!run || (tick && !state[1])) begin
      sk <= '0; vc <= '1; gc <= '0;
      valid <= 1'b0; in_gap <= 1'b0;
    end else if (tick) begin
      if (sk < TICK_W'(SKIP_TICKS)) begin
        sk    <= sk + 1'b1;
        valid <= 1'b0;
      end else if (!state[0]) begin
        valid <= 1'b1;
        vc    <= (!valid || vc == TICK_W'(BOOT_TICKS - 1))
               ? '0 : vc + 1'b1;
      end else if (in_gap) begin
        if (gc == TICK_W'(GAP_TICKS)) begin
          in_gap <= 1'b0;
          valid  <= 1'b1;
          vc     <= '0;
        end else begin
          gc <= gc + 1'b1;
        end
      end else if (valid && vc == TICK_W'(PAGE_TICKS - 1)) begin
        valid  <= 1'b0;
        in_gap <= 1'b1;
        gc     <= TICK_W'(1);
      end else begin
        valid <= 1'b1;
        vc    <= valid ? vc + 1'b1 : '0;
      end
    end
  end

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      abspos   <= POS_W'(INIT_POS);
      adv      <= 1'b0;
      posmatch <= 1'b0;
    end else begin
      adv      <= (ph == PH_W'(CYC_LEN - 1));
      posmatch <= adv && (abspos == bus.TARGETPOS);
      if (ph == PH_W'(CYC_LEN - 1))
        abspos <= (abspos == POS_W'(POS_COUNT - 1))
                ? '0 : abspos + 1'b1;
    end
  end

  assign bus.CLKOUT       = clkout;
  assign bus.ACCTYPE      = acctype;
  assign bus.BOUTVALID    = valid;
  assign bus.BOUTCYCLENUM = vc[TICK_W-1:2];
  assign bus.BOUTTICKS    = vc[1:0];
  assign bus.ABSPOS       = abspos;
  assign bus.POSMATCH     = posmatch;

endmodule

// File: tb/tb_bubble_timing_gen_p.sv
// Randomised bench for bubble_timing_gen_p against an
// arithmetic model of phase, tick and position timing.
module tb_bubble_timing_gen_p;
  import bubble_timing_pkg::*;

  localparam int CLKDIV = 6;
  localparam int CYC    = 16;
  localparam int Q      = CYC / 4;
  localparam int POS_W  = 12;
  localparam int PC     = 2053;
  localparam int INIT   = 2050;
  localparam int SYNC   = 4;
  localparam int SKIP   = 5;
  localparam int BOOT   = 12;
  localparam int PAGE   = 10;
  localparam int GAP    = 4;
  localparam int TW     = 8;

  logic MCLK  = 1'b0;
  logic RESET = 1'b1;
  int   cyc   = 0;
  int   errs  = 0;
  int   checks = 0;

  bubble_timing_gen_p_if #(
    .POS_W  (POS_W),
    .TICK_W (TW)
  ) bus ();

  bubble_timing_gen_p #(
    .CLKDIV      (CLKDIV),
    .CYC_LEN     (CYC),
    .POS_W       (POS_W),
    .POS_COUNT   (PC),
    .INIT_POS    (INIT),
    .SYNC_STAGES (SYNC),
    .SKIP_TICKS  (SKIP),
    .BOOT_TICKS  (BOOT),
    .PAGE_TICKS  (PAGE),
    .GAP_TICKS   (GAP),
    .TICK_W      (TW)
  ) dut (
    .MCLK  (MCLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 MCLK = ~MCLK;

  always @(posedge MCLK) cyc++;

  task automatic chk(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic wait_to(int target);
    int guard = 0;
    while (cyc < target && guard < 20000) begin
      @(negedge MCLK);
      guard++;
    end
    if (cyc != target) chk("wait_to", cyc, target);
  endtask

  task automatic chk_rst(string tag);
    chk({tag, "_acc"}, bus.ACCTYPE, ACC_RST);
    chk({tag, "_valid"}, bus.BOUTVALID, 0);
    chk({tag, "_cycnum"}, bus.BOUTCYCLENUM,
        (1 << (TW - 2)) - 1);
    chk({tag, "_ticks"}, bus.BOUTTICKS, 3);
    chk({tag, "_abspos"}, bus.ABSPOS, INIT);
    chk({tag, "_posmatch"}, bus.POSMATCH, 0);
  endtask

  task automatic idle_inputs();
    bus.nINCTRL   = 1'b1;
    bus.nBSS      = 1'b1;
    bus.nBSEN     = 1'b1;
    bus.nREPEN    = 1'b1;
    bus.nBOOTEN   = 1'b1;
    bus.TARGETPOS = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    int rel, d0, e, e1, e2, tgt, hits;
    int nb, n, n0, m, r, ev, epm;
    idle_inputs();
    repeat (3) @(negedge MCLK);
    #1;
    chk_rst("rst");
    chk("rst_clkout", bus.CLKOUT, 1);
    RESET = 1'b0;
    rel = cyc;

    // free run: CLKOUT toggles every CLKDIV edges
    for (int k = 1; k <= 1000; k++) begin
      @(negedge MCLK);
      chk("clkout", bus.CLKOUT,
          (((cyc - rel) / CLKDIV) % 2 == 0) ? 1 : 0);
    end
    chk_rst("idle");

    // bootloader loop: nBOOTEN low selects BOOT
    bus.nINCTRL = 1'b0;
    bus.nBOOTEN = 1'b0;
    tgt = (INIT + $urandom_range(1, 7)) % PC;
    bus.TARGETPOS = POS_W'(tgt);
    repeat ($urandom_range(2, 6)) @(negedge MCLK);
    bus.nBSS = 1'b0;
    d0 = cyc;
    wait_to(d0 + SYNC);
    chk("boot_pre_stby", bus.ACCTYPE, ACC_RST);
    wait_to(d0 + SYNC + 1);
    chk("boot_stby", bus.ACCTYPE, ACC_STBY);
    wait_to(d0 + 10 + $urandom_range(0, 3));
    bus.nBSS = 1'b1;
    repeat ($urandom_range(2, 6)) @(negedge MCLK);
    bus.nBSEN = 1'b0;
    e = cyc + SYNC + 1;
    wait_to(e - 1);
    chk("boot_pre", bus.ACCTYPE, ACC_STBY);
    wait_to(e);
    chk("boot_acc", bus.ACCTYPE, ACC_BOOT);

    hits = 0;
    nb = 1 + (SKIP + 2 * BOOT + 2) * Q;
    for (int t = 0; t <= nb; t++) begin
      wait_to(e + t);
      if (t >= 1 && (t - 1) % Q == 0) begin
        n  = (t - 1) / Q;
        ev = (n >= SKIP) ? 1 : 0;
        chk("boot_valid", bus.BOUTVALID, ev);
        if (ev == 1)
          chk("boot_count",
              {bus.BOUTCYCLENUM, bus.BOUTTICKS},
              (n - SKIP) % BOOT);
      end
      if (t % CYC == 0)
        chk("abspos", bus.ABSPOS, (INIT + t / CYC) % PC);
      epm = (t >= CYC + 1 && (t - 1) % CYC == 0 &&
             (INIT + (t - 1) / CYC) % PC == tgt) ? 1 : 0;
      chk("posmatch", bus.POSMATCH, epm);
      hits += int'(bus.POSMATCH);
    end
    chk("posmatch_count", hits, 1);

    // leave BOOT mid-cycle; ticks must clear
    repeat ($urandom_range(1, CYC)) @(negedge MCLK);
    bus.nBSEN = 1'b1;
    repeat (2 * CYC + SYNC + 4) @(negedge MCLK);
    chk("abort_acc", bus.ACCTYPE, ACC_RST);
    chk("abort_valid", bus.BOUTVALID, 0);
    chk("abort_cycnum", bus.BOUTCYCLENUM,
        (1 << (TW - 2)) - 1);

    // page sequence: nBOOTEN high selects USER
    bus.nBOOTEN = 1'b1;
    repeat ($urandom_range(2, 6)) @(negedge MCLK);
    bus.nBSS = 1'b0;
    d0 = cyc;
    wait_to(d0 + SYNC + 1);
    chk("page_stby", bus.ACCTYPE, ACC_STBY);
    wait_to(d0 + SYNC + 1 + $urandom_range(4, 8));
    bus.nBSS = 1'b1;
    repeat ($urandom_range(2, 6)) @(negedge MCLK);
    bus.nBSEN = 1'b0;
    e1 = cyc + SYNC + 1;
    wait_to(e1 - 1);
    chk("page_pre_idle", bus.ACCTYPE, ACC_STBY);
    wait_to(e1);
    chk("page_idle", bus.ACCTYPE, ACC_IDLE);
    repeat ($urandom_range(1, 20)) @(negedge MCLK);
    bus.nREPEN = 1'b0;
    e2 = cyc + SYNC + 1;
    wait_to(e2 - 1);
    chk("page_pre_user", bus.ACCTYPE, ACC_IDLE);
    wait_to(e2);
    chk("page_user", bus.ACCTYPE, ACC_USER);
    bus.nREPEN = 1'b1;

    n0 = (e2 - e1 - 1) / Q + 1;
    for (int i = 0; i <= SKIP + 2 * (PAGE + GAP) + 2; i++) begin
      n = n0 + i;
      wait_to(e1 + 1 + n * Q);
      m  = n - n0;
      r  = (m >= SKIP) ? (m - SKIP) % (PAGE + GAP) : 0;
      ev = (m >= SKIP && r < PAGE) ? 1 : 0;
      chk("page_valid", bus.BOUTVALID, ev);
      if (ev == 1)
        chk("page_count",
            {bus.BOUTCYCLENUM, bus.BOUTTICKS}, r);
    end
    chk("page_hold", bus.ACCTYPE, ACC_USER);

    // asynchronous reset in the middle of a page
    repeat ($urandom_range(1, 3)) @(negedge MCLK);
    RESET = 1'b1;
    #1;
    chk_rst("midrst");
    chk("midrst_clkout", bus.CLKOUT, 1);
    repeat (3) @(negedge MCLK);
    idle_inputs();
    RESET = 1'b0;
    repeat (2 * CYC + SYNC) @(negedge MCLK);
    chk("post_acc", bus.ACCTYPE, ACC_RST);
    chk("post_abspos", bus.ABSPOS, INIT);
    chk("post_valid", bus.BOUTVALID, 0);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
